// File: rtl/scr_base_l3_bk_rsp_sender_if.sv
// RSP sender bus bundle: per-cell request/ack lines toward the tracker
// cells, plus the flit output and the credit link toward the interconnect.
interface scr_base_l3_bk_rsp_sender_if #(
    parameter int CELL_NUM = 16,
    parameter int CELL_W   = 4,
    parameter int NODEID_W = 7,
    parameter int OPC_W    = 4,
    parameter int CRDT_MAX = 8
);
    localparam int FLIT_W = OPC_W + 2 * CELL_W + 2 * NODEID_W;
    localparam int CNT_W  = $clog2(CRDT_MAX + 1);

    logic [CELL_NUM-1:0]          rsp_req_vect_i;
    logic [CELL_NUM*OPC_W-1:0]    rsp_req_opc_i;
    logic [CELL_NUM*NODEID_W-1:0] rsp_req_tgtid_i;
    logic [CELL_NUM-1:0]          rsp_req_ack_vect_o;
    logic                         rsp_out_val_o;
    logic [FLIT_W-1:0]            rsp_out_flit_o;
    logic                         rsp_out_crdt_i;
    logic [CNT_W-1:0]             rsp_crdt_cnt_o;
    logic                         rsp_crdt_ovf_o;
    logic                         rsp_busy_o;

    // Sender side (the design)
    modport slave (
        input  rsp_req_vect_i, rsp_req_opc_i, rsp_req_tgtid_i, rsp_out_crdt_i,
        output rsp_req_ack_vect_o, rsp_out_val_o, rsp_out_flit_o,
        output rsp_crdt_cnt_o, rsp_crdt_ovf_o, rsp_busy_o
    );

    // Requester / link side
    modport master (
        output rsp_req_vect_i, rsp_req_opc_i, rsp_req_tgtid_i, rsp_out_crdt_i,
        input  rsp_req_ack_vect_o, rsp_out_val_o, rsp_out_flit_o,
        input  rsp_crdt_cnt_o, rsp_crdt_ovf_o, rsp_busy_o
    );
endinterface

// File: rtl/scr_base_l3_bk_rsp_sender.sv
// L3 bank RSP channel transmitter: round-robin arbitration over tracker
// cells, a small flit FIFO, and a credit-gated registered flit output.
module scr_base_l3_bk_rsp_sender #(
    parameter int SCR_BASE_L3_BK_CELL_NUM        = 16,
    parameter int SCR_BASE_L3_BK_CELL_W          = 4,
    parameter int SCR_BASE_L3_BK_NODEID_W        = 7,
    parameter int SCR_BASE_L3_BK_RSP_OPC_W       = 4,
    parameter int SCR_BASE_L3_BK_RSPS_FIFO_DEPTH = 4,
    parameter int SCR_BASE_L3_BK_RSPS_CRDT_MAX   = 8,
    parameter logic [SCR_BASE_L3_BK_NODEID_W-1:0] SCR_BASE_L3_BK_NODE_ID = 7'h10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    scr_base_l3_bk_rsp_sender_if.slave    rsp_if
);
    localparam int N      = SCR_BASE_L3_BK_CELL_NUM;
    localparam int CW     = SCR_BASE_L3_BK_CELL_W;
    localparam int NW     = SCR_BASE_L3_BK_NODEID_W;
    localparam int OW     = SCR_BASE_L3_BK_RSP_OPC_W;
    localparam int DEPTH  = SCR_BASE_L3_BK_RSPS_FIFO_DEPTH;
    localparam int CMAX   = SCR_BASE_L3_BK_RSPS_CRDT_MAX;
    localparam int FLIT_W = OW + 2 * CW + 2 * NW;
    localparam int CNT_W  = $clog2(CMAX + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    // Only DBID-carrying responses expose the cell index as DBID
    localparam logic [OW-1:0] OPC_COMPDBIDRESP = OW'(4'h5);
    localparam logic [OW-1:0] OPC_DBIDRESP     = OW'(4'h6);

    logic [FLIT_W-1:0] r_fifo_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_fifo_cnt;
    logic [CW-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]  r_crdt_cnt;
    logic              r_crdt_ovf;
    logic              r_out_val;
    logic [FLIT_W-1:0] r_out_flit;

    logic              w_full;
    logic              w_pop;
    logic              w_found;
    logic [CW:0]       w_sum;
    logic [CW-1:0]     w_cand;
    logic [CW-1:0]     w_grant_idx;
    logic              w_grant_vld;
    logic [N-1:0]      w_ack_vect;
    logic [OW-1:0]     w_opc;
    logic [NW-1:0]     w_tgtid;
    logic [CW-1:0]     w_dbid;
    logic [FLIT_W-1:0] w_push_flit;
    logic [CW-1:0]     w_rr_next;
    logic [CNT_W-1:0]  w_crdt_next;
    logic              w_ovf_set;

    assign w_full = (r_fifo_cnt == (PTR_W+1)'(DEPTH));
    // A flit leaves the FIFO only when there is something queued and a credit
    assign w_pop  = (r_fifo_cnt != '0) && (r_crdt_cnt != '0);

    // Round-robin search from r_rr_ptr; a grant needs FIFO room (or a same-cycle pop)
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_cand      = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (CW+1)'(i);
            if (w_sum >= (CW+1)'(N)) begin
                w_sum = w_sum - (CW+1)'(N);
            end else begin
                w_sum = w_sum;
            end
            w_cand = w_sum[CW-1:0];
            if (!w_found && rsp_if.rsp_req_vect_i[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end else begin
                w_found     = w_found;
            end
        end
        w_grant_vld = w_found && rst_n && (!w_full || w_pop);
        w_ack_vect  = '0;
        if (w_grant_vld) begin
            w_ack_vect[w_grant_idx] = 1'b1;
        end else begin
            w_ack_vect = '0;
        end
        if (w_grant_idx == CW'(N - 1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_grant_idx + CW'(1);
        end
    end

    // Pack the winning cell's request into a flit
    always_comb begin
        w_opc   = rsp_if.rsp_req_opc_i[w_grant_idx*OW +: OW];
        w_tgtid = rsp_if.rsp_req_tgtid_i[w_grant_idx*NW +: NW];
        if ((w_opc == OPC_DBIDRESP) || (w_opc == OPC_COMPDBIDRESP)) begin
            w_dbid = w_grant_idx;
        end else begin
            w_dbid = '0;
        end
        w_push_flit = {w_opc, w_grant_idx, w_dbid, SCR_BASE_L3_BK_NODE_ID, w_tgtid};
    end

    // Credit bookkeeping: +return -send, saturating at the maximum with a sticky error
    always_comb begin
        w_crdt_next = r_crdt_cnt;
        w_ovf_set   = 1'b0;
        if (rsp_if.rsp_out_crdt_i && !w_pop) begin
            if (r_crdt_cnt == CNT_W'(CMAX)) begin
                w_crdt_next = r_crdt_cnt;
                w_ovf_set   = 1'b1;
            end else begin
                w_crdt_next = r_crdt_cnt + CNT_W'(1);
            end
        end else if (!rsp_if.rsp_out_crdt_i && w_pop) begin
            w_crdt_next = r_crdt_cnt - CNT_W'(1);
        end else begin
            w_crdt_next = r_crdt_cnt;
        end
    end

    // FIFO storage; stale contents are harmless because the pointers are reset
    always_ff @(posedge clk) begin
        if (w_grant_vld) begin
            r_fifo_mem[r_wr_ptr] <= w_push_flit;
        end
    end

    // FIFO pointers, occupancy and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_grant_vld) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_rr_ptr <= w_rr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_grant_vld, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (PTR_W+1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (PTR_W+1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Registered flit output and credit state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_val  <= 1'b0;
            r_out_flit <= '0;
            r_crdt_cnt <= '0;
            r_crdt_ovf <= 1'b0;
        end else begin
            r_out_val  <= w_pop;
            if (w_pop) begin
                r_out_flit <= r_fifo_mem[r_rd_ptr];
            end
            r_crdt_cnt <= w_crdt_next;
            r_crdt_ovf <= r_crdt_ovf | w_ovf_set;
        end
    end

    assign rsp_if.rsp_req_ack_vect_o = w_ack_vect;
    assign rsp_if.rsp_out_val_o      = r_out_val;
    assign rsp_if.rsp_out_flit_o     = r_out_flit;
    assign rsp_if.rsp_crdt_cnt_o     = r_crdt_cnt;
    assign rsp_if.rsp_crdt_ovf_o     = r_crdt_ovf;
    assign rsp_if.rsp_busy_o         = (r_fifo_cnt != '0);
endmodule
